dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-port, byte-addressed, word-wide data memory. It shares the memory between port 0 (pipeline MEM stage) and port 1 (program loader / debug port). It serialises accesses through a registered two-state FSM and drives the memory's `MemWrite`/`MemRead`/`addr`/`Write_Data` inputs. It also rejects misaligned or out-of-range word accesses before they reach the array.

---
 rtl/dmem_arbiter_if.sv | 26 ++
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester ports and memory-side signals of dmem_arbiter
interface dmem_arbiter_if;
  logic        req0, req1;
  logic        we0, we1;
  logic [31:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1;
  logic        rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        err0, err1;
  logic        mem_write, mem_read;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
    output mem_write, mem_read, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
    input  mem_write, mem_read, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter/sequencer for the single-port word data memory
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES  = 1024,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic           clk,
  input  logic           reset_n,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 32'd4);

  state_t      state_q, state_d;
  logic        last1_q;
  logic        cmd_port_q, cmd_we_q, cmd_err_q;
  logic [31:0] cmd_addr_q, cmd_wdata_q;
  logic        gnt0_q, gnt1_q, rvalid0_q, rvalid1_q, err0_q, err1_q;
  logic [31:0] rdata0_q, rdata1_q;

  logic        any_req, win1, sel_we, sel_err;
  logic [31:0] sel_addr, sel_wdata, resp_data;

  // last1_q remembers the most recent grant; a tie goes to the other port
  always_comb begin
    any_req = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      win1 = FIXED_PRIO ? 1'b0 : ~last1_q;
    end else begin
      win1 = bus.req1;
    end
    sel_we    = win1 ? bus.we1    : bus.we0;
    sel_addr  = win1 ? bus.addr1  : bus.addr0;
    sel_wdata = win1 ? bus.wdata1 : bus.wdata0;
    sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr > MAX_ADDR);
    resp_data = (!cmd_we_q && !cmd_err_q) ? bus.mem_rdata : 32'h0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = BUSY;
      BUSY:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory strobes come straight from state so an async reset drops them at once
  always_comb begin
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    if (state_q == BUSY) begin
      bus.mem_write = cmd_we_q & ~cmd_err_q;
      bus.mem_read  = ~cmd_we_q & ~cmd_err_q;
      bus.mem_addr  = cmd_addr_q;
      bus.mem_wdata = cmd_wdata_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last1_q     <= 1'b1;
      cmd_port_q  <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_err_q   <= 1'b0;
      cmd_addr_q  <= 32'h0;
      cmd_wdata_q <= 32'h0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= 32'h0;
      rdata1_q    <= 32'h0;
    end else begin
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      if (state_q == IDLE && any_req) begin
        cmd_port_q  <= win1;
        cmd_we_q    <= sel_we;
        cmd_err_q   <= sel_err;
        cmd_addr_q  <= sel_addr;
        cmd_wdata_q <= sel_wdata;
        last1_q     <= win1;
        gnt0_q      <= ~win1;
        gnt1_q      <= win1;
      end
      if (state_q == BUSY) begin
        if (cmd_port_q) begin
          rvalid1_q <= 1'b1;
          rdata1_q  <= resp_data;
          err1_q    <= cmd_err_q;
        end else begin
          rvalid0_q <= 1'b1;
          rdata0_q  <= resp_data;
          err0_q    <= cmd_err_q;
        end
      end
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;
  assign bus.err0    = err0_q;
  assign bus.err1    = err1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst0_n, rst1_n;
  logic mem_loaded;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if bus0 ();
  dmem_arbiter_if bus1 ();

  dmem_arbiter #(.MEM_BYTES(1024), .FIXED_PRIO(1'b0)) dut0 (
    .clk(clk), .reset_n(rst0_n), .bus(bus0));
  dmem_arbiter #(.MEM_BYTES(1024), .FIXED_PRIO(1'b1)) dut1 (
    .clk(clk), .reset_n(rst1_n), .bus(bus1));

  // Word memory behind dut0, initial word i holds 0x1000_0000 + i
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + 32'(i);
    end else if (bus0.mem_write) begin
      mem[bus0.mem_addr[9:2]] <= bus0.mem_wdata;
    end
  end
  assign bus0.mem_rdata = mem[bus0.mem_addr[9:2]];
  assign bus1.mem_rdata = bus1.mem_addr ^ 32'h5A5A_0000;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus0.req0 = 1'b0; bus0.req1 = 1'b0; bus0.we0 = 1'b0; bus0.we1 = 1'b0;
    bus0.addr0 = 32'h0; bus0.addr1 = 32'h0; bus0.wdata0 = 32'h0; bus0.wdata1 = 32'h0;
    bus1.req0 = 1'b0; bus1.req1 = 1'b0; bus1.we0 = 1'b0; bus1.we1 = 1'b0;
    bus1.addr0 = 32'h0; bus1.addr1 = 32'h0; bus1.wdata0 = 32'h0; bus1.wdata1 = 32'h0;
  endtask

  // Single-port access on dut0 starting from IDLE
  task automatic run_vec(input int idx, input vec_t v);
    logic g, og, rv, orv, er;
    logic [31:0] rd;
    if (v.port) begin
      bus0.req1 = 1'b1; bus0.we1 = v.we; bus0.addr1 = v.addr; bus0.wdata1 = v.wdata;
    end else begin
      bus0.req0 = 1'b1; bus0.we0 = v.we; bus0.addr0 = v.addr; bus0.wdata0 = v.wdata;
    end
    @(posedge clk); #1;
    g  = v.port ? bus0.gnt1 : bus0.gnt0;
    og = v.port ? bus0.gnt0 : bus0.gnt1;
    chk1($sformatf("v%0d_gnt", idx), g, 1'b1);
    chk1($sformatf("v%0d_gnt_other", idx), og, 1'b0);
    chk1($sformatf("v%0d_mem_write", idx), bus0.mem_write, v.we & ~v.exp_err);
    chk1($sformatf("v%0d_mem_read", idx), bus0.mem_read, ~v.we & ~v.exp_err);
    if (!v.exp_err) chk32($sformatf("v%0d_mem_addr", idx), bus0.mem_addr, v.addr);
    bus0.req0 = 1'b0; bus0.req1 = 1'b0;
    @(posedge clk); #1;
    g   = v.port ? bus0.gnt1    : bus0.gnt0;
    rv  = v.port ? bus0.rvalid1 : bus0.rvalid0;
    orv = v.port ? bus0.rvalid0 : bus0.rvalid1;
    rd  = v.port ? bus0.rdata1  : bus0.rdata0;
    er  = v.port ? bus0.err1    : bus0.err0;
    chk1($sformatf("v%0d_gnt_drop", idx), g, 1'b0);
    chk1($sformatf("v%0d_rvalid", idx), rv, 1'b1);
    chk1($sformatf("v%0d_rvalid_other", idx), orv, 1'b0);
    chk32($sformatf("v%0d_rdata", idx), rd, v.exp_rdata);
    chk1($sformatf("v%0d_err", idx), er, v.exp_err);
    chk1($sformatf("v%0d_mem_idle", idx), bus0.mem_write | bus0.mem_read, 1'b0);
    @(posedge clk); #1;
    rv = v.port ? bus0.rvalid1 : bus0.rvalid0;
    chk1($sformatf("v%0d_rvalid_pulse", idx), rv, 1'b0);
  endtask

  initial begin
    int waited;
    vecs[0] = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,         1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF,  1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h13,  32'h11111111, 32'h0,         1'b1};
    vecs[3] = '{1'b1, 1'b1, 32'h3FD, 32'h22222222, 32'h0,         1'b1};
    vecs[4] = '{1'b0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF,  1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h3FC, 32'h0,        32'h100000FF,  1'b0};
    vecs[6] = '{1'b1, 1'b1, 32'h3FC, 32'hCAFEF00D, 32'h0,         1'b0};
    vecs[7] = '{1'b0, 1'b0, 32'h3FC, 32'h0,        32'hCAFEF00D,  1'b0};
    vecs[8] = '{1'b1, 1'b0, 32'h400, 32'h0,        32'h0,         1'b1};
    vecs[9] = '{1'b1, 1'b0, 32'h20,  32'h0,        32'h10000008,  1'b0};

    idle_inputs();
    mem_loaded = 1'b0;
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mem_loaded = 1'b1;
    chk1("rst_gnt0", bus0.gnt0, 1'b0);
    chk1("rst_gnt1", bus0.gnt1, 1'b0);
    chk1("rst_rvalid0", bus0.rvalid0, 1'b0);
    chk1("rst_rvalid1", bus0.rvalid1, 1'b0);
    chk1("rst_err0", bus0.err0, 1'b0);
    chk32("rst_rdata0", bus0.rdata0, 32'h0);
    chk1("rst_mem_write", bus0.mem_write, 1'b0);
    chk1("rst_mem_read", bus0.mem_read, 1'b0);
    chk32("rst_mem_addr", bus0.mem_addr, 32'h0);
    rst0_n = 1'b1;
    rst1_n = 1'b1;

    // Both ports read every cycle: round-robin on dut0, fixed priority on dut1
    bus0.req0 = 1'b1; bus0.req1 = 1'b1; bus0.addr0 = 32'h04; bus0.addr1 = 32'h08;
    bus1.req0 = 1'b1; bus1.req1 = 1'b1; bus1.addr0 = 32'h04; bus1.addr1 = 32'h08;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk1($sformatf("rr_gnt0_e%0d", k), bus0.gnt0, (k % 4) == 1);
      chk1($sformatf("rr_gnt1_e%0d", k), bus0.gnt1, (k % 4) == 3);
      chk1($sformatf("rr_rvalid0_e%0d", k), bus0.rvalid0, (k % 4) == 2);
      chk1($sformatf("rr_rvalid1_e%0d", k), bus0.rvalid1, (k % 4) == 0);
      if ((k % 4) == 2) chk32($sformatf("rr_rdata0_e%0d", k), bus0.rdata0, 32'h10000001);
      if ((k % 4) == 0) chk32($sformatf("rr_rdata1_e%0d", k), bus0.rdata1, 32'h10000002);
      chk1($sformatf("fp_gnt0_e%0d", k), bus1.gnt0, (k % 2) == 1);
      chk1($sformatf("fp_gnt1_e%0d", k), bus1.gnt1, 1'b0);
      chk1($sformatf("fp_rvalid0_e%0d", k), bus1.rvalid0, (k % 2) == 0);
    end
    bus0.req0 = 1'b0; bus0.req1 = 1'b0;
    bus1.req0 = 1'b0;
    @(posedge clk); #1;
    chk1("fp_gnt1_alone", bus1.gnt1, 1'b1);
    chk1("fp_gnt0_alone", bus1.gnt0, 1'b0);
    bus1.req1 = 1'b0;
    @(posedge clk); #1;
    chk1("fp_rvalid1", bus1.rvalid1, 1'b1);
    chk32("fp_rdata1", bus1.rdata1, 32'h5A5A0008);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Port 0 arrives while port 1 occupies the BUSY cycle
    bus0.req1 = 1'b1; bus0.we1 = 1'b0; bus0.addr1 = 32'h20;
    @(posedge clk); #1;
    chk1("busy_gnt1", bus0.gnt1, 1'b1);
    bus0.req1 = 1'b0;
    bus0.req0 = 1'b1; bus0.we0 = 1'b0; bus0.addr0 = 32'h04;
    @(posedge clk); #1;
    chk1("busy_ignore_gnt0", bus0.gnt0, 1'b0);
    chk1("busy_rvalid1", bus0.rvalid1, 1'b1);
    waited = 0;
    while (!bus0.gnt0 && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    chk1("busy_gnt0_seen", bus0.gnt0, 1'b1);
    chk32("busy_gnt0_latency", 32'(waited), 32'd1);
    bus0.req0 = 1'b0;
    @(posedge clk); #1;
    chk1("busy_rvalid0", bus0.rvalid0, 1'b1);
    chk32("busy_rdata0", bus0.rdata0, 32'h10000001);
    @(posedge clk); #1;

    // Reset during the BUSY cycle of a write abandons it
    bus0.req0 = 1'b1; bus0.we0 = 1'b1; bus0.addr0 = 32'h20; bus0.wdata0 = 32'h12345678;
    @(posedge clk); #1;
    chk1("rstw_gnt0", bus0.gnt0, 1'b1);
    chk1("rstw_mem_write_busy", bus0.mem_write, 1'b1);
    bus0.req0 = 1'b0; bus0.we0 = 1'b0;
    #2;
    rst0_n = 1'b0;
    #1;
    chk1("rstw_mem_write_drop", bus0.mem_write, 1'b0);
    chk1("rstw_gnt0_drop", bus0.gnt0, 1'b0);
    chk32("rstw_mem_addr", bus0.mem_addr, 32'h0);
    @(posedge clk); #1;
    chk1("rstw_no_rvalid", bus0.rvalid0, 1'b0);
    @(posedge clk); #1;
    rst0_n = 1'b1;
    @(posedge clk); #1;
    chk1("rstw_no_rvalid_after", bus0.rvalid0, 1'b0);

    // Pointer is back at port 1, so port 0 wins the first tie
    bus0.req0 = 1'b1; bus0.req1 = 1'b1; bus0.addr0 = 32'h08; bus0.addr1 = 32'h0C;
    @(posedge clk); #1;
    chk1("rst_tie_gnt0", bus0.gnt0, 1'b1);
    chk1("rst_tie_gnt1", bus0.gnt1, 1'b0);
    bus0.req0 = 1'b0;
    @(posedge clk); #1;
    chk32("rst_tie_rdata0", bus0.rdata0, 32'h10000002);
    @(posedge clk); #1;
    chk1("rst_tie_gnt1_next", bus0.gnt1, 1'b1);
    bus0.req1 = 1'b0;
    @(posedge clk); #1;
    chk32("rst_tie_rdata1", bus0.rdata1, 32'h10000003);
    @(posedge clk); #1;

    run_vec(10, '{1'b0, 1'b0, 32'h20, 32'h0, 32'h10000008, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
